// File: rtl/wb_spi_slave_if.sv
// Wishbone slave port bundle for wb_spi_slave.
interface wb_spi_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_spi_slave.sv
// SPI mode-0 target with one-byte RX buffer and one-byte TX hold, exposed on Wishbone.
//   state   | meaning
//   S_ARM   | after reset: wait until the select pin is seen released
//   S_IDLE  | select released; waiting for a select falling edge
//   S_FRAME | selected; shifting bytes on sck edges
module wb_spi_slave #(
  parameter int unsigned clk_freq = 100000000
) (
  input  logic            clk,
  input  logic            reset,
  wb_spi_slave_if.slave   wb,
  input  logic            spi_sck,
  input  logic            spi_ss_n,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic            spi_miso_oe,
  output logic            intr
);

  typedef enum logic [1:0] {S_ARM, S_IDLE, S_FRAME} state_t;

  state_t      state, state_nxt;
  logic [2:0]  sck_s, ss_s;
  logic [1:0]  mosi_s;
  logic        sync_valid;
  logic [2:0]  bitcnt;
  logic [7:0]  rx_sh, tx_sh, tx_next, rx_byte;
  logic [7:0]  rx_buf, tx_hold;
  logic        rx_full, tx_full, ovr;
  logic [1:0]  ctrl;
  logic        sck_rise, sck_fall, ss_rise, ss_fall;
  logic        tx_load, tx_shift, rx_shift, bit_clr, byte_done;
  logic        access, rd, wr, rd_rx, wr_tx, wr_st, wr_ctl;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                         wb.wb_dat_i[31:8], rx_sh[7], tx_sh[7]} ^ (clk_freq == 0);

  // Index 1 is the synchronized level, index 2 the delayed copy for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s      <= 3'b000;
      ss_s       <= 3'b111;
      mosi_s     <= 2'b00;
      sync_valid <= 1'b0;
      state      <= S_ARM;
    end else begin
      sck_s      <= {sck_s[1:0], spi_sck};
      ss_s       <= {ss_s[1:0], spi_ss_n};
      mosi_s     <= {mosi_s[0], spi_mosi};
      sync_valid <= 1'b1;
      state      <= state_nxt;
    end
  end

  assign sck_rise    = sck_s[1] & ~sck_s[2];
  assign sck_fall    = ~sck_s[1] & sck_s[2];
  assign ss_fall     = ~ss_s[1] & ss_s[2];
  assign ss_rise     = ss_s[1] & ~ss_s[2];
  assign spi_miso_oe = ~ss_s[1];

  // A select that is already low when reset releases is not a frame start.
  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    rx_shift  = 1'b0;
    bit_clr   = 1'b0;
    case (state)
      S_ARM:  if (sync_valid && (&ss_s)) state_nxt = S_IDLE;
      S_IDLE: if (ss_fall) begin
        state_nxt = S_FRAME;
        bit_clr   = 1'b1;
        tx_load   = 1'b1;
      end
      S_FRAME: begin
        if (ss_rise) begin
          state_nxt = S_IDLE;
          bit_clr   = 1'b1;
        end else begin
          rx_shift = sck_rise;
          if (sck_fall) begin
            if (bitcnt == 3'd0) tx_load  = 1'b1;
            else                tx_shift = 1'b1;
          end
        end
      end
      default: state_nxt = S_ARM;
    endcase
  end

  assign tx_next   = tx_full ? tx_hold : 8'hFF;
  assign rx_byte   = {rx_sh[6:0], mosi_s[1]};
  assign byte_done = rx_shift && (bitcnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt   <= 3'd0;
      rx_sh    <= 8'h00;
      tx_sh    <= 8'hFF;
      spi_miso <= 1'b1;
    end else begin
      if (bit_clr) bitcnt <= 3'd0;
      if (rx_shift) begin
        rx_sh  <= rx_byte;
        bitcnt <= bitcnt + 3'd1;
      end
      if (tx_load) begin
        tx_sh    <= tx_next;
        spi_miso <= tx_next[7];
      end else if (tx_shift) begin
        tx_sh    <= {tx_sh[6:0], 1'b1};
        spi_miso <= tx_sh[6];
      end
    end
  end

  assign access = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
  assign rd     = access & ~wb.wb_we_i;
  assign wr     = access & wb.wb_we_i;
  assign rd_rx  = rd && (wb.wb_adr_i[3:2] == 2'd0);
  assign wr_tx  = wr && (wb.wb_adr_i[3:2] == 2'd1);
  assign wr_st  = wr && (wb.wb_adr_i[3:2] == 2'd2);
  assign wr_ctl = wr && (wb.wb_adr_i[3:2] == 2'd3);

  always_comb begin
    rd_mux = 32'h0;
    case (wb.wb_adr_i[3:2])
      2'd0:    rd_mux = {24'h0, rx_buf};
      2'd2:    rd_mux = {28'h0, ~ss_s[1], ovr, tx_full, rx_full};
      2'd3:    rd_mux = {30'h0, ctrl};
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= 32'h0;
      rx_full     <= 1'b0;
      tx_full     <= 1'b0;
      ovr         <= 1'b0;
      ctrl        <= 2'b00;
      rx_buf      <= 8'h00;
      tx_hold     <= 8'h00;
    end else begin
      wb.wb_ack_o <= access;
      if (rd) wb.wb_dat_o <= rd_mux;
      // A pop in the completion cycle frees the buffer for the new byte.
      if (byte_done) begin
        if (!rx_full || rd_rx) begin
          rx_buf  <= rx_byte;
          rx_full <= 1'b1;
        end
      end else if (rd_rx) begin
        rx_full <= 1'b0;
      end
      if (wr_st && wb.wb_dat_i[2]) ovr <= 1'b0;
      if (byte_done && rx_full && !rd_rx) ovr <= 1'b1;
      if (tx_load && tx_full) tx_full <= 1'b0;
      if (wr_tx) begin
        tx_hold <= wb.wb_dat_i[7:0];
        tx_full <= 1'b1;
      end
      if (wr_ctl) ctrl <= wb.wb_dat_i[1:0];
    end
  end

  assign intr = (rx_full & ctrl[0]) | (ovr & ctrl[1]);

endmodule

// File: tb/tb_wb_spi_slave.sv
// Self-checking bench for wb_spi_slave: drives an SPI master and Wishbone reads/writes.
module tb_wb_spi_slave;
  logic clk = 1'b0;
  logic reset;
  logic spi_sck, spi_ss_n, spi_mosi;
  logic spi_miso, spi_miso_oe, intr;

  wb_spi_slave_if bus ();

  wb_spi_slave #(.clk_freq(100000000)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (bus.slave),
    .spi_sck     (spi_sck),
    .spi_ss_n    (spi_ss_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .intr        (intr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic m_rx_full = 1'b0, m_tx_full = 1'b0, m_ovr = 1'b0;
  logic [31:0] hit_dat;
  logic [31:0] d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input logic busy);
    return {28'h0, busy, m_ovr, m_tx_full, m_rx_full};
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rdat);
    int n;
    @(negedge clk);
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wb_ack_o && n < 10);
    if (!bus.wb_ack_o) chk("wb_ack_timeout", {31'h0, bus.wb_ack_o}, 32'h1);
    rdat = bus.wb_dat_o;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic rd_rx();
    logic [31:0] r;
    logic [7:0]  e;
    wb_xfer(1'b0, 32'h0, 32'h0, r);
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
    chk("rxdata", r, {24'h0, e});
    m_rx_full = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic busy);
    logic [31:0] r;
    wb_xfer(1'b0, 32'h8, 32'h0, r);
    chk(tag, r, stat_exp(busy));
  endtask

  task automatic spi_bit(input logic b, input logic rd_hit, output logic m);
    spi_mosi = b;
    repeat (6) @(negedge clk);
    m = spi_miso;
    spi_sck = 1'b1;
    if (rd_hit) begin
      @(negedge clk);
      wb_xfer(1'b0, 32'h0, 32'h0, hit_dat);
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic rd_last, output logic [7:0] mb);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], rd_last && (i == 0), m);
      mb[i] = m;
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] mb;
    spi_byte(tx, 1'b0, mb);
    if (tx_q.size() > 0) chk("miso_byte", {24'h0, mb}, {24'h0, tx_q.pop_front()});
    if (!m_rx_full) begin
      rx_q.push_back(tx);
      m_rx_full = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic ss_lo();
    @(negedge clk);
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_hi();
    repeat (6) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic m;
    logic [7:0] mb;
    reset = 1'b1;
    spi_sck = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h0; bus.wb_dat_i = 32'h0; bus.wb_sel_i = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
    chk("rst_dat", bus.wb_dat_o, 32'h0);
    chk("rst_intr", {31'h0, intr}, 32'h0);
    chk("rst_miso", {31'h0, spi_miso}, 32'h1);
    chk("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk_status("rst_status", 1'b0);
    @(negedge clk);
    chk("ack_one_cycle", {31'h0, bus.wb_ack_o}, 32'h0);
    wb_xfer(1'b0, 32'hC, 32'h0, d);
    chk("rst_ctrl", d, 32'h0);

    // single receive
    wb_xfer(1'b1, 32'hC, 32'h1, d);
    ss_lo();
    chk("oe_selected", {31'h0, spi_miso_oe}, 32'h1);
    send(8'hA5);
    chk("rx_intr", {31'h0, intr}, 32'h1);
    chk_status("rx_status", 1'b1);
    ss_hi();
    rd_rx();
    chk("rx_intr_clr", {31'h0, intr}, 32'h0);
    chk_status("rx_status_clr", 1'b0);

    // transmit: TXHOLD then idle 0xFF
    wb_xfer(1'b1, 32'h4, 32'h3C, d);
    m_tx_full = 1'b1;
    chk_status("tx_full_set", 1'b0);
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hFF);
    ss_lo();
    m_tx_full = 1'b0;
    send(8'h01);
    send(8'h02);
    ss_hi();
    chk_status("tx_status", 1'b0);
    rd_rx();
    wb_xfer(1'b1, 32'h8, 32'h4, d);
    m_ovr = 1'b0;

    // back-to-back with read between
    ss_lo();
    send(8'h11);
    rd_rx();
    send(8'h22);
    ss_hi();
    rd_rx();
    chk_status("b2b_status", 1'b0);

    // overrun
    ss_lo();
    send(8'h11);
    send(8'h22);
    ss_hi();
    chk_status("ovr_status", 1'b0);
    wb_xfer(1'b1, 32'hC, 32'h2, d);
    rd_rx();
    chk("ovr_intr", {31'h0, intr}, 32'h1);
    wb_xfer(1'b1, 32'h8, 32'h4, d);
    m_ovr = 1'b0;
    chk_status("ovr_cleared", 1'b0);
    chk("ovr_intr_clr", {31'h0, intr}, 32'h0);
    wb_xfer(1'b1, 32'hC, 32'h3, d);
    wb_xfer(1'b0, 32'hC, 32'h0, d);
    chk("ctrl_rb", d, 32'h3);

    // abort after 5 bits
    ss_lo();
    for (int i = 0; i < 5; i++) spi_bit(1'b0, 1'b0, m);
    ss_hi();
    chk_status("abort_none", 1'b0);
    ss_lo();
    send(8'h81);
    ss_hi();
    rd_rx();
    chk_status("abort_one", 1'b0);

    // read collides with byte completion
    ss_lo();
    send(8'h5A);
    spi_byte(8'hC3, 1'b1, mb);
    chk("collide_rd", hit_dat, {24'h0, rx_q.pop_front()});
    rx_q.push_back(8'hC3);
    ss_hi();
    chk_status("collide_status", 1'b0);
    rd_rx();

    // reset mid-byte
    ss_lo();
    send(8'h77);
    ss_hi();
    wb_xfer(1'b1, 32'h4, 32'h00, d);
    ss_lo();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, m);
    chk("pre_rst_miso", {31'h0, spi_miso}, 32'h0);
    chk("pre_rst_intr", {31'h0, intr}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
    chk("mid_rst_dat", bus.wb_dat_o, 32'h0);
    chk("mid_rst_intr", {31'h0, intr}, 32'h0);
    chk("mid_rst_miso", {31'h0, spi_miso}, 32'h1);
    chk("mid_rst_oe", {31'h0, spi_miso_oe}, 32'h0);
    reset = 1'b0;
    rx_q.delete();
    m_rx_full = 1'b0; m_tx_full = 1'b0; m_ovr = 1'b0;
    for (int i = 0; i < 8; i++) spi_bit(1'b1, 1'b0, m);
    chk_status("post_rst_ignored", 1'b1);
    ss_hi();
    wb_xfer(1'b0, 32'hC, 32'h0, d);
    chk("post_rst_ctrl", d, 32'h0);
    ss_lo();
    send(8'h3E);
    ss_hi();
    rd_rx();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/wb_spi_slave.md
# wb_spi_slave

SPI target (slave) peripheral with a Wishbone slave register port, the responder for an external SPI master. It lets an off-chip controller exchange bytes with the LM32 firmware through the conbus. It mirrors the on-chip `wb_spi` master: the external device drives `spi_sck`/`spi_ss_n`, and this block shifts data in and out. It buffers one received byte and one transmit byte.

## Interface
- `clk_freq`, default 100000000: system clock in Hz; documentation only, no logic depends on it.
- `clk`  in  1: system clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `wb_adr_i`  in  32: byte address; only bits [3:2] are decoded.
- `wb_dat_i`  in  32: write data.
- `wb_dat_o`  out  32: read data.
- `wb_sel_i`  in  4: byte select; ignored, so every access is a full-register access.
- `wb_stb_i`, `wb_cyc_i`, `wb_we_i`  in  1 each: Wishbone strobe, cycle and write enable.
- `wb_ack_o`  out  1: Wishbone acknowledge.
- `spi_sck`  in  1: external SPI clock, mode 0 (CPOL=0, CPHA=0).
- `spi_ss_n`  in  1: active-low select.
- `spi_mosi`  in  1: data from the external master.
- `spi_miso`  out  1: data to the external master.
- `spi_miso_oe`  out  1: MISO output enable; equals the synchronized select (high while selected).
- `intr`  out  1: level interrupt.

## Operation
- **Input synchronization:** `spi_sck`, `spi_ss_n` and `spi_mosi` pass through 2-flop synchronizers. A third flop on sck and ss_n gives edge detection.
- **Frame format:** 8-bit, MSB first.
  - Sample MOSI on the synchronized sck rising edge.
  - Update MISO on the synchronized sck falling edge.
- **Shift state:** `bitcnt` is 3 bits, `rx_sh` is 8 bits, `tx_sh` is 8 bits.
- **Select falling edge:**
  - `bitcnt` := 0.
  - `tx_sh` := TXHOLD if `tx_full`, else 0xFF. In the first case `tx_full` := 0.
  - `spi_miso` := `tx_sh[7]` of the newly loaded value.
- **sck rising edge while selected:**
  - `rx_sh` := {`rx_sh[6:0]`, mosi}.
  - `bitcnt` increments; it wraps from 7 to 0.
  - When `bitcnt` was 7 the byte is complete:
    - If `rx_full` = 0: RXBUF := the new byte and `rx_full` := 1.
    - If `rx_full` = 1: `ovr` := 1 and RXBUF keeps its old value.
- **sck falling edge while selected:**
  - If `bitcnt` = 0 (a byte boundary, back-to-back byte): reload `tx_sh` as on a select falling edge.
  - Otherwise shift `tx_sh` left.
  - `spi_miso` := the new `tx_sh[7]`.
- **Select rising edge:** any partial byte is discarded and `bitcnt` := 0. `rx_full`, `tx_full` and `ovr` are not changed.
- **Registers** (offset decoded from `wb_adr_i[3:2]`):
  - 0x0 RXDATA (R): returns {24'h0, RXBUF}. A read clears `rx_full`.
  - 0x4 TXDATA (W): TXHOLD := `wb_dat_i[7:0]` and `tx_full` := 1. A write while `tx_full` = 1 overwrites TXHOLD.
  - 0x8 STATUS (R): {28'h0, busy, ovr, tx_full, rx_full}, where busy = synchronized select active.
  - 0x8 STATUS (W): writing 1 to bit 2 clears `ovr`.
  - 0xC CTRL (R/W): bit0 = `rx_ie`, bit1 = `ovr_ie`.
  - Writes to read-only registers have no effect. Reads of write-only registers return 0.
- **Interrupt:** `intr` = (`rx_full` & `rx_ie`) | (`ovr` & `ovr_ie`).
- **Simultaneous events:**
  - RXDATA read in the same cycle a byte completes: the read returns the old RXBUF, the new byte is stored, `rx_full` stays 1, and `ovr` is not set.
  - TXDATA write in the same cycle `tx_sh` loads: the load takes the old TXHOLD (or 0xFF if TXHOLD was empty), the write lands in TXHOLD, and `tx_full` ends at 1.
  - STATUS clear in the same cycle an overrun occurs: the set wins and `ovr` stays 1.
- **Reset values:**
  - `wb_ack_o`=0, `wb_dat_o`=0, `intr`=0.
  - `spi_miso`=1, `spi_miso_oe`=0.
  - `rx_full`=0, `tx_full`=0, `ovr`=0, CTRL=0, RXBUF=0, TXHOLD=0, `bitcnt`=0.
  - The synchronizers reset to idle: sck=0, ss_n=1.
- **Reset mid-frame:** the block returns to the reset state immediately. The rest of that frame is ignored until the next select falling edge.

## Timing
- **Wishbone access:**
  - `wb_ack_o` rises the cycle after `stb & cyc & ~ack` and lasts exactly 1 cycle.
  - Back-to-back accesses take 2 cycles each.
  - `wb_dat_o` is registered and valid with ack. Side effects (pop, load, clear) take effect in the ack cycle.
- **SPI edge latency:** 3 clk cycles from a pin edge to the internal edge strobe.
- **MISO:** valid 4 clk cycles after the sck falling edge or the select falling edge.
- **Clock limits:**
  - The spi_sck high and low phases must each be ≥ 4 clk cycles, so f_sck ≤ clk_freq/8.
  - The first sck rising edge must come ≥ 5 clk cycles after the ss_n falling edge.
- **RXDATA:** `rx_full` is visible in STATUS 1 cycle after the internal edge that completes the byte.

## Test plan
- **Single receive:** CTRL=1; master sends 0xA5 → RXDATA=0x000000A5, `intr`=1 after the 8th edge; after the RXDATA read, `rx_full`=0 and `intr`=0.
- **Transmit:** write TXDATA=0x3C, then the master clocks 1 byte → MISO bits 0,0,1,1,1,1,0,0 and `tx_full`=0. A second byte without a new TXDATA write returns 0xFF.
- **Back-to-back:** 2 bytes 0x11, 0x22 under one select, with RXDATA read between them → reads are 0x11 then 0x22, and `ovr`=0.
- **Overrun:** 2 bytes with no read → RXDATA=0x11, STATUS bit2=1. Writing 0x4 to STATUS clears `ovr`.
- **Abort:** deassert ss_n after 5 bits, then send a full byte 0x81 → RXDATA=0x81 and only one byte is received.
- **Collisions:**
  - RXDATA read on the completion cycle → the old byte is returned and `rx_full` stays 1.
  - Reset asserted mid-byte → all outputs return to their reset values.
